// File: rtl/reflet_pwm_pkg.sv
// Shared definitions for the reflet PWM blocks: default word size, ramp FSM
// state encoding and the all-ones constant used for saturating arithmetic.
package reflet_pwm_pkg;

  localparam int WORD_SIZE_DEFAULT  = 8;
  localparam int RATE_WIDTH_DEFAULT = 8;

  localparam logic [WORD_SIZE_DEFAULT-1:0] ALL_ONES = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/reflet_pwm_period_counter.sv
// Free-running period counter 0..max, flagging the last cycle of each period.
// Shares reset with reflet_pwm_pwm so both counters stay phase-aligned.
module reflet_pwm_period_counter #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] max_i,
  output logic                 period_end_o
);

  logic [WORD_SIZE-1:0] cnt_q, cnt_d;

  // max only changes on a period_end edge, when cnt restarts at 0 anyway.
  assign period_end_o = (cnt_q == max_i);

  always_comb begin
    cnt_d = period_end_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reflet_pwm_ramp.sv
// Drives duty_cycle/max of reflet_pwm_pwm, stepping duty toward a commanded
// target and updating both only at period boundaries.
module reflet_pwm_ramp
  import reflet_pwm_pkg::*;
#(
  parameter int WORD_SIZE  = reflet_pwm_pkg::WORD_SIZE_DEFAULT,
  parameter int RATE_WIDTH = reflet_pwm_pkg::RATE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WORD_SIZE-1:0]  cmd_target,
  input  logic [WORD_SIZE-1:0]  cmd_max,
  input  logic [RATE_WIDTH-1:0] cmd_rate,
  output logic [WORD_SIZE-1:0]  duty_cycle,
  output logic [WORD_SIZE-1:0]  max,
  output logic                  period_end,
  output logic                  busy,
  output logic                  done
);

  localparam logic [WORD_SIZE-1:0] MaxWord = '1;

  ramp_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0]  duty_q, duty_d;
  logic [WORD_SIZE-1:0]  max_q, max_d;
  logic [WORD_SIZE-1:0]  max_pend_q, max_pend_d;
  logic [WORD_SIZE-1:0]  tgt_q, tgt_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [RATE_WIDTH-1:0] rate_cnt_q, rate_cnt_d;
  logic                  done_q, done_d;
  logic [WORD_SIZE-1:0]  max_plus;
  logic [WORD_SIZE-1:0]  tgt_clamped;

  reflet_pwm_period_counter #(
    .WORD_SIZE(WORD_SIZE)
  ) u_period_counter (
    .clk          (clk),
    .reset        (reset),
    .max_i        (max_q),
    .period_end_o (period_end)
  );

  // duty = max+1 is always-on downstream, so that is the highest useful target.
  assign max_plus    = (cmd_max == MaxWord) ? MaxWord : cmd_max + 1'b1;
  assign tgt_clamped = (cmd_target > max_plus) ? max_plus : cmd_target;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    max_d      = max_q;
    max_pend_d = max_pend_q;
    tgt_d      = tgt_q;
    rate_d     = rate_q;
    rate_cnt_d = rate_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d      = tgt_clamped;
          max_pend_d = cmd_max;
          rate_d     = cmd_rate;
          rate_cnt_d = '0;
          state_d    = RAMP;
        end
      end
      RAMP: begin
        if (period_end) begin
          max_d = max_pend_q;
          if (duty_q == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (rate_cnt_q == rate_q) begin
            duty_d     = (duty_q < tgt_q) ? duty_q + 1'b1 : duty_q - 1'b1;
            rate_cnt_d = '0;
          end else begin
            rate_cnt_d = rate_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      max_q      <= MaxWord;
      max_pend_q <= MaxWord;
      tgt_q      <= '0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      max_q      <= max_d;
      max_pend_q <= max_pend_d;
      tgt_q      <= tgt_d;
      rate_q     <= rate_d;
      rate_cnt_q <= rate_cnt_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RAMP);
  assign done       = done_q;
  assign duty_cycle = duty_q;
  assign max        = max_q;

endmodule

// File: tb/tb_reflet_pwm_ramp.sv
// Directed bench for reflet_pwm_ramp: each accepted command pushes the expected
// per-period_end (duty, max, done) results, popped as period boundaries occur.
module tb_reflet_pwm_ramp;
  import reflet_pwm_pkg::*;

  localparam int W  = 8;
  localparam int RW = 8;

  typedef struct {
    int duty;
    int maxv;
    int done;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic [W-1:0]  cmdTarget = '0;
  logic [W-1:0]  cmdMax = '0;
  logic [RW-1:0] cmdRate = '0;
  logic [W-1:0]  dutyCycle;
  logic [W-1:0]  maxOut;
  logic          periodEnd;
  logic          busy;
  logic          done;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   mCnt = 0;
  int   mMax = 255;
  int   mDuty = 0;
  int   mDone = 0;

  always #5 clk = ~clk;

  reflet_pwm_ramp dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmdValid),
    .cmd_ready  (cmdReady),
    .cmd_target (cmdTarget),
    .cmd_max    (cmdMax),
    .cmd_rate   (cmdRate),
    .duty_cycle (dutyCycle),
    .max        (maxOut),
    .period_end (periodEnd),
    .busy       (busy),
    .done       (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Closed-form expectation: step k of the ramp has moved min(k/(R+1), N) units.
  task automatic pushRamp(input int target, input int mx, input int rate);
    int   tgt;
    int   n;
    int   total;
    int   steps;
    exp_t e;
    tgt = (mx + 1 > 255) ? 255 : mx + 1;
    if (target < tgt) tgt = target;
    n = (tgt > mDuty) ? tgt - mDuty : mDuty - tgt;
    total = n * (rate + 1) + 1;
    for (int k = 1; k <= total; k++) begin
      steps = k / (rate + 1);
      if (steps > n) steps = n;
      e.duty = (tgt >= mDuty) ? mDuty + steps : mDuty - steps;
      e.maxv = mx;
      e.done = (k == total) ? 1 : 0;
      expQ.push_back(e);
    end
  endtask

  task automatic stepCycle();
    int   pe;
    bit   accept;
    exp_t e;
    @(negedge clk);
    pe = (mCnt == mMax) ? 1 : 0;
    checkOutput("period_end", periodEnd, pe);
    accept = cmdValid && (expQ.size() == 0);
    @(posedge clk);
    mDone = 0;
    if (pe == 1 && expQ.size() != 0) begin
      e = expQ.pop_front();
      mDuty = e.duty;
      mMax  = e.maxv;
      mDone = e.done;
    end
    mCnt = (pe == 1) ? 0 : mCnt + 1;
    if (accept) pushRamp(cmdTarget, cmdMax, cmdRate);
    #1;
    checkOutput("duty_cycle", dutyCycle, mDuty);
    checkOutput("max", maxOut, mMax);
    checkOutput("done", done, mDone);
    checkOutput("busy", busy, (expQ.size() != 0) ? 1 : 0);
    checkOutput("cmd_ready", cmdReady, (expQ.size() == 0) ? 1 : 0);
  endtask

  task automatic applyStimulus(input int target, input int mx, input int rate);
    cmdTarget = W'(target);
    cmdMax    = W'(mx);
    cmdRate   = RW'(rate);
    cmdValid  = 1'b1;
    stepCycle();
    cmdValid  = 1'b0;
  endtask

  task automatic runToIdle(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      stepCycle();
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL ramp_timeout observed=busy expected=idle within %0d cycles", budget);
      expQ.delete();
    end
  endtask

  initial begin
    int n;
    $display("[TB] reset phase");
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ready_in_reset", cmdReady, 1);
    reset = 1'b0;
    checkOutput("rst_duty", dutyCycle, 0);
    checkOutput("rst_max", maxOut, ALL_ONES);
    checkOutput("rst_ready", cmdReady, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);

    $display("[TB] ramp up 0->3, max 4, rate 0");
    applyStimulus(3, 4, 0);
    runToIdle(2000);
    stepCycle();

    $display("[TB] ramp down 3->0, rate 1, with ignored mid-ramp command");
    applyStimulus(0, 4, 1);
    repeat (7) stepCycle();
    cmdTarget = 8'd9;
    cmdMax    = 8'd2;
    cmdValid  = 1'b1;
    stepCycle();
    cmdValid  = 1'b0;
    runToIdle(500);

    $display("[TB] target 20 clamped to max+1 = 10");
    applyStimulus(20, 9, 0);
    runToIdle(500);
    checkOutput("clamp_final_duty", dutyCycle, 10);

    $display("[TB] back to 0 with max 0");
    applyStimulus(0, 0, 0);
    runToIdle(500);

    $display("[TB] max 0: target 5 clamps to 1, done two cycles after accept");
    applyStimulus(5, 0, 0);
    stepCycle();
    stepCycle();
    checkOutput("max0_done_latency", done, 1);
    checkOutput("max0_duty", dutyCycle, 1);
    runToIdle(10);

    $display("[TB] target equal to current duty");
    applyStimulus(1, 0, 3);
    runToIdle(10);

    $display("[TB] reset mid-ramp");
    applyStimulus(6, 3, 0);
    n = 0;
    while (mDuty != 2 && n < 100) begin
      stepCycle();
      n++;
    end
    checkOutput("pre_reset_duty", dutyCycle, 2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    expQ.delete();
    mDuty = 0;
    mMax  = 255;
    mCnt  = 0;
    mDone = 0;
    checkOutput("async_rst_duty", dutyCycle, 0);
    checkOutput("async_rst_max", maxOut, 255);
    checkOutput("async_rst_ready", cmdReady, 1);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_rst_done", done, 0);
    reset = 1'b0;
    applyStimulus(2, 2, 0);
    checkOutput("accept_after_reset", busy, 1);
    runToIdle(2000);
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
